// File: rtl/exp_handler_imem.sv
// exp_handler_imem: writable trap-handler instruction store with per-cause vector table, reset sweep and loader port
module exp_handler_imem #(
    parameter logic [31:0] BASE_ADDR = 32'h1c09_0000,
    parameter int          DEPTH     = 64,
    parameter int          NUM_VEC   = 8,
    parameter logic [31:0] INIT_WORD = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_req,
    input  logic [31:0]                fetch_addr,
    input  logic                       fetch_stall,
    output logic                       fetch_ready,
    output logic                       fetch_valid,
    output logic [31:0]                fetch_data,
    output logic                       fetch_hit,
    output logic                       fetch_misalign,
    input  logic                       cause_req,
    input  logic [$clog2(NUM_VEC)-1:0] cause,
    output logic                       vec_valid,
    output logic [31:0]                vec_target,
    input  logic                       prog_en,
    input  logic                       prog_we,
    input  logic                       prog_vec_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [31:0]                prog_wdata,
    output logic                       init_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_VEC);

    typedef enum logic [1:0] {INIT, READY, PROG} state_t;

    state_t      state;
    logic [AW-1:0] ptr;
    logic [31:0] mem [DEPTH];
    logic [31:0] vec [NUM_VEC];
    logic [31:0] off;
    logic        in_win, aligned, accept, hit, lookup;

    // Lower bound checked first so the offset compare can never see a wrapped value
    assign off         = fetch_addr - BASE_ADDR;
    assign in_win      = fetch_addr >= BASE_ADDR && off < 32'(4 * DEPTH);
    assign aligned     = fetch_addr[1:0] == 2'b00;
    assign accept      = state == READY && fetch_req && !fetch_stall;
    assign hit         = accept && in_win && aligned;
    assign lookup      = cause_req && state != INIT;
    assign fetch_ready = state == READY;

    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[ptr] <= INIT_WORD;
        else if (state == PROG && prog_we)
            mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= INIT;
            ptr            <= '0;
            init_done      <= 1'b0;
            fetch_valid    <= 1'b0;
            fetch_data     <= '0;
            fetch_hit      <= 1'b0;
            fetch_misalign <= 1'b0;
            vec_valid      <= 1'b0;
            vec_target     <= '0;
            for (int k = 0; k < NUM_VEC; k++)
                vec[k] <= BASE_ADDR + 32'(4 * k);
        end else begin
            case (state)
                INIT: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == AW'(DEPTH - 1)) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                READY:   state <= prog_en ? PROG : READY;
                PROG:    state <= prog_en ? PROG : READY;
                default: state <= INIT;
            endcase
            if (state == PROG && prog_vec_we)
                vec[CW'(prog_addr)] <= prog_wdata;
            if (!fetch_stall) begin
                fetch_valid    <= accept;
                fetch_data     <= hit ? mem[off[AW+1:2]] : '0;
                fetch_hit      <= hit;
                fetch_misalign <= accept && !aligned;
            end
            vec_valid  <= lookup;
            vec_target <= lookup ? vec[cause] : '0;
        end
    end
endmodule

// File: tb/tb_exp_handler_imem.sv
// tb_exp_handler_imem: directed self-checking bench for exp_handler_imem (default parameters)
module tb_exp_handler_imem;
    localparam int DEPTH = 64;
    localparam logic [31:0] BASE = 32'h1c09_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0, fetch_stall = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_ready, fetch_valid, fetch_hit, fetch_misalign;
    logic [31:0] fetch_data;
    logic        cause_req = 1'b0;
    logic [2:0]  cause = '0;
    logic        vec_valid;
    logic [31:0] vec_target;
    logic        prog_en = 1'b0, prog_we = 1'b0, prog_vec_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [31:0] prog_wdata = '0;
    logic        init_done;

    int checks = 0;
    int fails = 0;
    logic bad;

    exp_handler_imem dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .fetch_hit(fetch_hit), .fetch_misalign(fetch_misalign),
        .cause_req(cause_req), .cause(cause), .vec_valid(vec_valid), .vec_target(vec_target),
        .prog_en(prog_en), .prog_we(prog_we), .prog_vec_we(prog_vec_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic lookup(input logic [2:0] c);
        cause_req = 1'b1;
        cause = c;
        tick();
        cause_req = 1'b0;
    endtask

    task automatic sweep(input string tag);
        bad = 1'b0;
        rst_n = 1'b1;
        cause_req = 1'b1;
        fetch_req = 1'b1;
        fetch_addr = BASE;
        repeat (DEPTH - 1) begin
            tick();
            bad |= fetch_ready | fetch_valid | vec_valid | init_done;
        end
        check({tag, "_init_quiet"}, {31'b0, bad}, 32'd0);
        tick();
        cause_req = 1'b0;
        fetch_req = 1'b0;
        check({tag, "_init_done"}, {31'b0, init_done}, 32'd1);
        check({tag, "_ready"}, {31'b0, fetch_ready}, 32'd1);
    endtask

    initial begin
        tick();
        tick();
        check("rst_outs", {init_done, fetch_ready, fetch_valid, fetch_hit, fetch_misalign, vec_valid},
              32'd0);
        check("rst_data", fetch_data | vec_target, 32'd0);
        sweep("first");

        fetch(BASE);
        check("nop_valid", {fetch_valid, fetch_hit, fetch_misalign}, 32'b110);
        check("nop_data", fetch_data, NOP);
        tick();
        check("idle_valid", {31'b0, fetch_valid}, 32'd0);
        lookup(3'd5);
        check("vec_rst", vec_target, 32'h1c09_0014);
        check("vec_valid", {31'b0, vec_valid}, 32'd1);

        prog_en = 1'b1;
        tick();
        check("prog_notready", {31'b0, fetch_ready}, 32'd0);
        prog_we = 1'b1; prog_addr = 6'd2; prog_wdata = 32'hff81_0113;
        tick();
        prog_we = 1'b1; prog_vec_we = 1'b1; prog_addr = 6'd5; prog_wdata = 32'h1c09_0080;
        tick();
        prog_we = 1'b0; prog_vec_we = 1'b1; prog_addr = 6'd3; prog_wdata = 32'h1c09_0040;
        lookup(3'd3);
        check("vec_same_cycle_old", vec_target, 32'h1c09_000c);
        prog_vec_we = 1'b0;
        prog_en = 1'b0;
        tick();
        prog_we = 1'b1; prog_addr = 6'd2; prog_wdata = 32'hdead_beef;
        tick();
        prog_we = 1'b0;
        fetch(BASE + 32'h8);
        check("raw_word2", fetch_data, 32'hff81_0113);
        fetch(BASE + 32'h14);
        check("dual_word5", fetch_data, 32'h1c09_0080);
        lookup(3'd3);
        check("vec3_new", vec_target, 32'h1c09_0040);
        lookup(3'd5);
        check("vec5_dual", vec_target, 32'h1c09_0080);

        fetch(BASE + 32'h100);
        check("oow_flags", {fetch_valid, fetch_hit, fetch_misalign}, 32'b100);
        check("oow_data", fetch_data, 32'd0);
        fetch(BASE + 32'hfc);
        check("last_word", {fetch_data[30:0], fetch_hit}, {NOP[30:0], 1'b1});
        fetch(BASE - 32'h4);
        check("below_win", {fetch_valid, fetch_hit}, 32'b10);
        fetch(32'hffff_fffc);
        check("top_addr", {fetch_valid, fetch_hit}, 32'b10);
        fetch(BASE + 32'h6);
        check("misalign_flags", {fetch_valid, fetch_hit, fetch_misalign}, 32'b101);
        check("misalign_data", fetch_data, 32'd0);

        fetch(BASE + 32'h8);
        fetch_stall = 1'b1;
        fetch_req = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = BASE + 32'h14 + 32'(4 * i);
            tick();
            bad |= fetch_data !== 32'hff81_0113 || fetch_valid !== 1'b1 || fetch_hit !== 1'b1;
        end
        check("stall_hold", {31'b0, bad}, 32'd0);
        fetch_stall = 1'b0;
        fetch(BASE + 32'h14);
        check("stall_release", fetch_data, 32'h1c09_0080);
        tick();
        check("post_release_idle", {31'b0, fetch_valid}, 32'd0);

        fetch_req = 1'b1; fetch_addr = BASE; prog_en = 1'b1;
        tick();
        check("prog_edge_fetch", {fetch_valid, fetch_hit, fetch_ready}, 32'b110);
        bad = 1'b0;
        repeat (4) begin
            tick();
            bad |= fetch_valid | fetch_ready;
        end
        check("prog_no_fetch", {31'b0, bad}, 32'd0);
        prog_en = 1'b0;
        tick();
        check("prog_exit_edge", {31'b0, fetch_valid}, 32'd0);
        tick();
        fetch_req = 1'b0;
        check("prog_exit_fetch", {fetch_valid, fetch_hit}, 32'b11);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check("midsweep_rst", {init_done, fetch_ready, vec_valid}, 32'd0);
        tick();
        sweep("second");
        fetch(BASE + 32'h8);
        check("resweep_word2", fetch_data, NOP);
        lookup(3'd3);
        check("resweep_vec3", vec_target, 32'h1c09_000c);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/exp_handler_imem.md
Name: exp_handler_imem

Overview:
- Parametrised, writable instruction store for the exception/trap handler region of the pipeline. It replaces the fixed combinational handler table.
- Serves instruction fetches inside a configurable address window with one-cycle registered latency.
- Provides a per-cause vector table of handler entry points.
- After reset, sweeps all contents to NOP. A loader can then overwrite handler code and vectors at run time.

Parameters:
- BASE_ADDR, 32'h1c09_0000, byte address of word 0 of the handler window.
- DEPTH, 64, number of 32-bit words; power of two, 4..1024.
- NUM_VEC, 8, number of cause vectors; power of two, 2..32.
- INIT_WORD, 32'h0000_0013, value written to every word by the reset sweep (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  32  byte address of the fetch.
- fetch_stall  in  1  pipeline stall; holds the fetch outputs.
- fetch_ready  out  1  fetch accepted this cycle (state READY).
- fetch_valid  out  1  fetch_data valid (response cycle).
- fetch_data  out  32  instruction word.
- fetch_hit  out  1  responded address lay inside the window and was aligned.
- fetch_misalign  out  1  responded address had addr[1:0]!=0.
- cause_req  in  1  vector lookup request.
- cause  in  $clog2(NUM_VEC)  exception cause index.
- vec_valid  out  1  vec_target valid.
- vec_target  out  32  handler entry address for the cause.
- prog_en  in  1  loader owns the block (state PROG).
- prog_we  in  1  write handler word.
- prog_vec_we  in  1  write vector entry.
- prog_addr  in  $clog2(DEPTH)  word index (for a vector write, low bits select the cause).
- prog_wdata  in  32  write data.
- init_done  out  1  reset sweep complete.

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT, sweep pointer=0.
  - All outputs 0.
  - vector k reset to BASE_ADDR + 4*k.
  - Word storage is not reset directly; the sweep initialises it.
- FSM transitions:
  - INIT: writes INIT_WORD at the pointer each cycle and increments the pointer. When the pointer reaches DEPTH-1 and that word is written, go to READY and set init_done=1 (sticky until reset). The sweep takes DEPTH cycles.
  - INIT ignores prog_* and fetch_req. fetch_ready=0 throughout INIT.
  - READY: if prog_en=1, go to PROG next cycle. Otherwise serve fetches.
  - PROG: fetch_ready=0. Go to READY when prog_en=0.
- Loader writes:
  - In PROG, prog_we writes prog_wdata to word[prog_addr] at the clock edge.
  - prog_vec_we writes vector[prog_addr[$clog2(NUM_VEC)-1:0]].
  - If both are set in the same cycle, both writes occur.
  - Writes outside PROG are ignored.
- Fetch (READY, fetch_req=1, fetch_stall=0), one cycle later:
  - fetch_valid=1.
  - In-window and aligned (BASE_ADDR <= addr < BASE_ADDR+4*DEPTH, addr[1:0]==0): fetch_data=word[(addr-BASE_ADDR)>>2], fetch_hit=1.
  - Outside the window: fetch_data=0, fetch_hit=0.
  - Misaligned: fetch_data=0, fetch_hit=0, fetch_misalign=1.
- fetch_stall=1: fetch_valid, fetch_data, fetch_hit and fetch_misalign hold their values, and no new fetch is accepted.
- No fetch accepted (fetch_req=0 with no stall, or state not READY): fetch_valid=0 next cycle.
- Read-after-write: a word written in PROG is returned by the first fetch accepted after the return to READY.
- Entering PROG while a response is held by stall: the response keeps holding until the stall drops. It then clears, because no new fetch is accepted.
- Vector lookup: cause_req=1 in READY or PROG gives vec_valid=1 and vec_target=vector[cause] one cycle later.
  - A same-cycle prog_vec_we to the same cause returns the old value.
  - cause_req in INIT is ignored (vec_valid=0).
- Address arithmetic is 32-bit unsigned; the window check does not wrap past 32'hffff_ffff.
- Reset mid-sweep or mid-PROG returns to INIT, clears init_done and restarts the sweep from word 0.

Test Plan:
- Reset, then idle DEPTH cycles -> init_done rises exactly DEPTH cycles after rst_n deasserts. A fetch of 32'h1c09_0000 then returns 32'h0000_0013 with fetch_hit=1, one cycle after acceptance.
- Enter PROG. Write word 2=32'hff81_0113 and vector 3=32'h1c09_0040. Drop prog_en. Fetch 32'h1c09_0008 -> fetch_data=32'hff81_0113. Look up cause=3 -> vec_target=32'h1c09_0040.
- Fetch 32'h1c09_0100 (DEPTH=64, outside window) -> fetch_valid=1, fetch_data=0, fetch_hit=0. Fetch 32'h1c09_0006 -> fetch_misalign=1, fetch_data=0.
- Accept a fetch, then assert fetch_stall for 3 cycles while changing fetch_addr -> outputs hold the first response. Release the stall -> the next request is served.
- Pulse rst_n low at sweep cycle 20 -> init_done stays 0 and the sweep restarts. init_done rises DEPTH cycles after the second deassertion. fetch_ready=0 throughout INIT.
- Hold prog_en and fetch_req together in READY -> one fetch is accepted in the transition cycle. fetch_ready=0 in PROG and no further fetch_valid pulses until prog_en drops.
